cpu_bus_capture: RTL and testbench

- Front-end stage between the raw 2A03 cartridge bus and the mapper register logic.
- Runs on osc50. Synchronises and filters M2, and time-aligns the address, data, R/W and /ROMSEL samples to the filtered M2.
- At the end of each valid CPU cycle it emits a one-cycle write or read event carrying the full 16-bit CPU address ({~romsel, cpu_addr_in}).
- Mapper register blocks decode these events in the osc50 domain instead of clocking on M2.

---
 rtl/cpu_bus_capture_pkg.sv | 33 +++
 rtl/cpu_bus_capture_if.sv | 33 +++
 rtl/cpu_bus_capture_sync_filter.sv | 54 +++++
 rtl/cpu_bus_capture.sv | 168 ++++++++++++++++
 tb/tb_cpu_bus_capture.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/cpu_bus_capture_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_bus_pkg: shared types, FSM states and register addresses. Rev 1.0
// ---------------------------------------------------------------------------
package cpu_bus_pkg;

  typedef logic [15:0] cpu_addr_t;
  typedef logic [7:0]  cpu_data_t;

  typedef enum logic [1:0] {
    ST_LOW  = 2'd0,
    ST_HIGH = 2'd1,
    ST_EMIT = 2'd2
  } cap_state_t;

  typedef struct packed {
    logic        rw;
    logic        romsel;
    logic [14:0] addr;
    cpu_data_t   data;
  } bus_sample_t;

  localparam cpu_addr_t REG_8000 = 16'h8000;
  localparam cpu_addr_t REG_5000 = 16'h5000;
  localparam cpu_addr_t REG_5001 = 16'h5001;

  // /ROMSEL is active low, so its inverse restores CPU address bit 15.
  function automatic cpu_addr_t full_addr(input bus_sample_t s);
    return {~s.romsel, s.addr};
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_bus_capture_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_bus_capture_if: raw cartridge bus inputs and captured event outputs. Rev 1.0
// ---------------------------------------------------------------------------
interface cpu_bus_capture_if;
  import cpu_bus_pkg::*;

  logic        m2;
  logic        romsel;
  logic        cpu_rw_in;
  logic [14:0] cpu_addr_in;
  cpu_data_t   cpu_data;

  logic        wr_valid;
  logic        rd_valid;
  cpu_addr_t   bus_addr;
  cpu_data_t   bus_data;
  logic        m2_high;
  logic        runt_err;
  logic        m2_idle;

  modport master (
    output m2, romsel, cpu_rw_in, cpu_addr_in, cpu_data,
    input  wr_valid, rd_valid, bus_addr, bus_data, m2_high, runt_err, m2_idle
  );

  modport slave (
    input  m2, romsel, cpu_rw_in, cpu_addr_in, cpu_data,
    output wr_valid, rd_valid, bus_addr, bus_data, m2_high, runt_err, m2_idle
  );

endinterface
`default_nettype wire

// File: rtl/cpu_bus_capture_sync_filter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_filter: SYNC_STAGES synchroniser followed by an M2_FILT-sample debounce. Rev 1.0
// ---------------------------------------------------------------------------
module sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int M2_FILT     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level
);

  localparam int CW = $clog2(M2_FILT + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   level_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];
  assign level  = level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Any sample agreeing with the current level restarts the run count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      level_q <= 1'b0;
    end else if (synced != level_q) begin
      if (cnt == CW'(M2_FILT - 1)) begin
        level_q <= synced;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cpu_bus_capture.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_bus_capture: turns filtered M2 cycles into osc50-domain read/write events.
// Optional M2 idle detector via CPU_M2_IDLE_DETECT_EN. Rev 1.0
// ---------------------------------------------------------------------------
module cpu_bus_capture
  import cpu_bus_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int M2_FILT      = 2,
  parameter int MIN_HIGH     = 6
`ifdef CPU_M2_IDLE_DETECT_EN
  ,
  parameter int IDLE_TIMEOUT = 4096
`endif
) (
  input  logic               osc50,
  input  logic               m2_rst,
  cpu_bus_capture_if.slave   bus
);

  localparam int DEPTH = SYNC_STAGES + M2_FILT;

  logic        m2_high;
  bus_sample_t raw;
  bus_sample_t pipe [DEPTH];
  bus_sample_t aligned;

  cap_state_t  state, state_nxt;
  logic [7:0]  hi_cnt, hi_cnt_nxt;
  bus_sample_t shadow, shadow_nxt;
  logic        wr_q, wr_nxt;
  logic        rd_q, rd_nxt;
  logic        runt_q, runt_nxt;
  cpu_addr_t   addr_q, addr_nxt;
  cpu_data_t   data_q, data_nxt;

  sync_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .M2_FILT     (M2_FILT)
  ) u_m2_filter (
    .clk   (osc50),
    .rst_n (m2_rst),
    .din   (bus.m2),
    .level (m2_high)
  );

  assign raw = '{rw: bus.cpu_rw_in, romsel: bus.romsel,
                 addr: bus.cpu_addr_in, data: bus.cpu_data};

  // Synchroniser and filter-alignment delay share one shift register.
  always_ff @(posedge osc50 or negedge m2_rst) begin
    if (!m2_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= raw;
      for (int i = 1; i < DEPTH; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign aligned = pipe[DEPTH-1];

  always_ff @(posedge osc50 or negedge m2_rst) begin
    if (!m2_rst) begin
      state  <= ST_LOW;
      hi_cnt <= '0;
      shadow <= '0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      runt_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state  <= state_nxt;
      hi_cnt <= hi_cnt_nxt;
      shadow <= shadow_nxt;
      wr_q   <= wr_nxt;
      rd_q   <= rd_nxt;
      runt_q <= runt_nxt;
      addr_q <= addr_nxt;
      data_q <= data_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    hi_cnt_nxt = hi_cnt;
    shadow_nxt = shadow;
    wr_nxt     = 1'b0;
    rd_nxt     = 1'b0;
    runt_nxt   = 1'b0;
    addr_nxt   = addr_q;
    data_nxt   = data_q;
    case (state)
      ST_LOW: begin
        if (m2_high) begin
          state_nxt  = ST_HIGH;
          hi_cnt_nxt = 8'd1;
          shadow_nxt = aligned;
        end
      end
      ST_HIGH: begin
        if (!m2_high) begin
          state_nxt = ST_EMIT;
        end else begin
          if (hi_cnt != 8'hFF) begin
            hi_cnt_nxt = hi_cnt + 8'd1;
          end
          shadow_nxt = aligned;
        end
      end
      ST_EMIT: begin
        if (hi_cnt >= 8'(MIN_HIGH)) begin
          addr_nxt = full_addr(shadow);
          data_nxt = shadow.data;
          wr_nxt   = ~shadow.rw;
          rd_nxt   = shadow.rw;
        end else begin
          runt_nxt = 1'b1;
        end
        if (m2_high) begin
          state_nxt  = ST_HIGH;
          hi_cnt_nxt = 8'd1;
          shadow_nxt = aligned;
        end else begin
          state_nxt = ST_LOW;
        end
      end
      default: state_nxt = ST_LOW;
    endcase
  end

  assign bus.wr_valid = wr_q;
  assign bus.rd_valid = rd_q;
  assign bus.runt_err = runt_q;
  assign bus.bus_addr = addr_q;
  assign bus.bus_data = data_q;
  assign bus.m2_high  = m2_high;

`ifdef CPU_M2_IDLE_DETECT_EN
  logic        m2_high_d;
  logic [12:0] idle_cnt;

  always_ff @(posedge osc50 or negedge m2_rst) begin
    if (!m2_rst) begin
      m2_high_d <= 1'b0;
      idle_cnt  <= '0;
    end else begin
      m2_high_d <= m2_high;
      if (m2_high != m2_high_d) begin
        idle_cnt <= '0;
      end else if (idle_cnt != 13'h1FFF) begin
        idle_cnt <= idle_cnt + 13'd1;
      end
    end
  end

  assign bus.m2_idle = (idle_cnt >= 13'(IDLE_TIMEOUT));
`else
  assign bus.m2_idle = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_capture.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cpu_bus_capture: directed self-checking bench for cpu_bus_capture. Rev 1.0
// ---------------------------------------------------------------------------
module tb_cpu_bus_capture;

  logic osc50 = 1'b0;
  logic m2_rst;
  int   checks = 0;
  int   errors = 0;
  logic idle_seen = 1'b0;

  int          wr_n, rd_n, runt_n, wr_at, rd_at, hi_n;
  logic [15:0] ev_addr;
  logic [7:0]  ev_data;

  cpu_bus_capture_if bus ();

  cpu_bus_capture dut (
    .osc50  (osc50),
    .m2_rst (m2_rst),
    .bus    (bus)
  );

  always #10 osc50 = ~osc50;

  task automatic drive_cycle(input logic rw, input logic rs, input logic [14:0] a,
                             input logic [7:0] d, input int hi_cycles);
    @(negedge osc50);
    bus.cpu_rw_in   = rw;
    bus.romsel      = rs;
    bus.cpu_addr_in = a;
    bus.cpu_data    = d;
    bus.m2          = 1'b1;
    repeat (hi_cycles) @(negedge osc50);
    bus.m2 = 1'b0;
  endtask

  // k = 0 is the first osc50 edge after the caller's last stimulus change.
  task automatic observe(input int n);
    wr_n = 0; rd_n = 0; runt_n = 0; wr_at = -1; rd_at = -1; hi_n = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge osc50);
      #1;
      if (bus.wr_valid) begin wr_n++; wr_at = k; ev_addr = bus.bus_addr; ev_data = bus.bus_data; end
      if (bus.rd_valid) begin rd_n++; rd_at = k; ev_addr = bus.bus_addr; ev_data = bus.bus_data; end
      if (bus.runt_err) runt_n++;
      if (bus.m2_high)  hi_n++;
      if (bus.m2_idle)  idle_seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    m2_rst = 1'b0;
    bus.m2 = 1'b0; bus.romsel = 1'b1; bus.cpu_rw_in = 1'b1;
    bus.cpu_addr_in = '0; bus.cpu_data = '0;
    repeat (3) @(posedge osc50);
    #1;
    checks++; if (bus.wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr got %b want 0", bus.wr_valid); end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd got %b want 0", bus.rd_valid); end
    checks++; if (bus.runt_err !== 1'b0) begin errors++; $display("FAIL reset_runt got %b want 0", bus.runt_err); end
    checks++; if (bus.m2_high !== 1'b0) begin errors++; $display("FAIL reset_m2_high got %b want 0", bus.m2_high); end
    checks++; if (bus.bus_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr got %h want 0000", bus.bus_addr); end
    checks++; if (bus.bus_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", bus.bus_data); end
    checks++; if (bus.m2_idle !== 1'b0) begin errors++; $display("FAIL reset_idle got %b want 0", bus.m2_idle); end
    @(negedge osc50);
    m2_rst = 1'b1;
    repeat (4) @(negedge osc50);
  endtask

  task automatic test_write;
    drive_cycle(1'b0, 1'b0, 15'h0000, 8'hA5, 15);
    observe(12);
    checks++; if (wr_n !== 1) begin errors++; $display("FAIL write_count got %0d want 1", wr_n); end
    checks++; if (wr_at !== 5) begin errors++; $display("FAIL write_latency got %0d want 5", wr_at); end
    checks++; if (rd_n !== 0) begin errors++; $display("FAIL write_no_rd got %0d want 0", rd_n); end
    checks++; if (ev_addr !== 16'h8000) begin errors++; $display("FAIL write_addr got %h want 8000", ev_addr); end
    checks++; if (ev_data !== 8'hA5) begin errors++; $display("FAIL write_data got %h want a5", ev_data); end
    checks++; if (bus.bus_data !== 8'hA5) begin errors++; $display("FAIL write_hold got %h want a5", bus.bus_data); end
  endtask

  task automatic test_read;
    drive_cycle(1'b1, 1'b1, 15'h5001, 8'h77, 15);
    observe(12);
    checks++; if (rd_n !== 1) begin errors++; $display("FAIL read_count got %0d want 1", rd_n); end
    checks++; if (rd_at !== 5) begin errors++; $display("FAIL read_latency got %0d want 5", rd_at); end
    checks++; if (wr_n !== 0) begin errors++; $display("FAIL read_no_wr got %0d want 0", wr_n); end
    checks++; if (ev_addr !== 16'h5001) begin errors++; $display("FAIL read_addr got %h want 5001", ev_addr); end
  endtask

  task automatic test_glitch;
    drive_cycle(1'b0, 1'b0, 15'h0123, 8'h11, 1);
    observe(12);
    checks++; if (hi_n !== 0) begin errors++; $display("FAIL glitch_m2_high got %0d cycles want 0", hi_n); end
    checks++; if (wr_n + rd_n !== 0) begin errors++; $display("FAIL glitch_valid got %0d want 0", wr_n + rd_n); end
    checks++; if (runt_n !== 0) begin errors++; $display("FAIL glitch_runt got %0d want 0", runt_n); end
  endtask

  task automatic test_runt;
    drive_cycle(1'b0, 1'b0, 15'h1234, 8'h5A, 4);
    observe(12);
    checks++; if (runt_n !== 1) begin errors++; $display("FAIL runt_count got %0d want 1", runt_n); end
    checks++; if (wr_n + rd_n !== 0) begin errors++; $display("FAIL runt_valid got %0d want 0", wr_n + rd_n); end
    checks++; if (bus.bus_addr !== 16'h5001) begin errors++; $display("FAIL runt_addr_hold got %h want 5001", bus.bus_addr); end
  endtask

  task automatic test_reset_mid;
    @(negedge osc50);
    bus.cpu_rw_in = 1'b0; bus.romsel = 1'b0; bus.cpu_addr_in = 15'h0000; bus.cpu_data = 8'hEE;
    bus.m2 = 1'b1;
    repeat (8) @(negedge osc50);
    m2_rst = 1'b0;
    #1;
    checks++; if ({bus.wr_valid, bus.rd_valid, bus.runt_err, bus.m2_high} !== 4'b0000) begin
      errors++; $display("FAIL midrst_flags got %b want 0000", {bus.wr_valid, bus.rd_valid, bus.runt_err, bus.m2_high}); end
    checks++; if ({bus.bus_addr, bus.bus_data} !== 24'h0) begin
      errors++; $display("FAIL midrst_bus got %h want 000000", {bus.bus_addr, bus.bus_data}); end
    bus.m2 = 1'b0;
    repeat (3) @(negedge osc50);
    m2_rst = 1'b1;
    observe(12);
    checks++; if (wr_n + rd_n + runt_n !== 0) begin errors++; $display("FAIL midrst_events got %0d want 0", wr_n + rd_n + runt_n); end
    drive_cycle(1'b0, 1'b0, 15'h0000, 8'h3C, 15);
    observe(12);
    checks++; if (wr_n !== 1 || wr_at !== 5) begin errors++; $display("FAIL midrst_write got count %0d at %0d want 1 at 5", wr_n, wr_at); end
    checks++; if ({ev_addr, ev_data} !== 24'h80003C) begin errors++; $display("FAIL midrst_write_bus got %h want 80003c", {ev_addr, ev_data}); end
  endtask

  task automatic test_idle;
`ifdef CPU_M2_IDLE_DETECT_EN
    repeat (4100) @(posedge osc50);
    #1;
    checks++; if (bus.m2_idle !== 1'b1) begin errors++; $display("FAIL idle_set got %b want 1", bus.m2_idle); end
    drive_cycle(1'b1, 1'b1, 15'h5000, 8'h00, 15);
    observe(12);
    checks++; if (bus.m2_idle !== 1'b0) begin errors++; $display("FAIL idle_clear got %b want 0", bus.m2_idle); end
    checks++; if (rd_n !== 1 || ev_addr !== 16'h5000) begin errors++; $display("FAIL idle_read got %0d/%h want 1/5000", rd_n, ev_addr); end
`else
    checks++; if (idle_seen !== 1'b0) begin errors++; $display("FAIL idle_tied got %b want 0", idle_seen); end
`endif
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_glitch();
    test_runt();
    test_reset_mid();
    test_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
